// File: rtl/rle_seq_pkg.sv
// Shared types and defaults for the run-length line sequencer.
package rle_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StExpand,
      StDone
   } seq_state_e;

   localparam int unsigned LineWDefault = 640;
   localparam int unsigned LinesDefault = 480;
   localparam int unsigned RunWDefault  = 10;

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/rle_pos_counter.sv
// Pixel position counter: x within the line, y within the frame, and the
// last-pixel / last-line detects used by the sequencer FSM.
module rle_pos_counter
   import rle_seq_pkg::*;
#(
   parameter int unsigned LINE_W = LineWDefault,
   parameter int unsigned LINES  = LinesDefault
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear,
   input  logic step,
   output logic at_line_end,
   output logic last_line
);

   localparam int unsigned XW = cnt_w(LINE_W);
   localparam int unsigned YW = cnt_w(LINES);
   localparam logic [XW-1:0] XLast = XW'(LINE_W - 1);
   localparam logic [YW-1:0] YLast = YW'(LINES - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign at_line_end = (x_q == XLast);
   assign last_line   = (y_q == YLast);

   // Advance one pixel per step; y returns to 0 after the last line.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (step) begin
         if (at_line_end) begin
            x_d = '0;
            y_d = last_line ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Position registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/rle_line_sequencer.sv
// Run-length to pixel sequencer. Consumes run words, expands them into a
// one-bit pixel stream toward a VGA FIFO, and frames lines and frames.
// Optional macro RLE_SEQ_LINE_CHECK_EN: truncate runs that cross a line end
// and raise the sticky err_overflow flag.
// pix_valid/pix_out/line_end are gated by fifo_full in the same cycle so a
// stall never loses or duplicates a pixel; a new_im cycle emits nothing.
module rle_line_sequencer
   import rle_seq_pkg::*;
#(
   parameter int unsigned LINE_W = LineWDefault,
   parameter int unsigned LINES  = LinesDefault,
   parameter int unsigned RUN_W  = RunWDefault
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             new_im,
   input  logic [RUN_W-1:0] run_data,
   input  logic             run_valid,
   output logic             run_ready,
   input  logic             fifo_full,
   output logic             pix_out,
   output logic             pix_valid,
   output logic             line_end,
   output logic             frame_end,
   output logic             frame_abort,
   output logic             err_overflow
);

   seq_state_e       state_q, state_d;
   logic [RUN_W-1:0] remaining_q, remaining_d;
   logic             symbol_q, symbol_d;
   logic             abort_q, abort_d;
`ifdef RLE_SEQ_LINE_CHECK_EN
   logic             err_q, err_d;
`endif

   logic xfer, emit, run_last, at_line_end, last_line;

   assign xfer     = (state_q == StLoad) && run_valid;
   assign emit     = (state_q == StExpand) && !fifo_full && !new_im;
   assign run_last = (remaining_q == RUN_W'(1));

   rle_pos_counter #(
      .LINE_W(LINE_W),
      .LINES (LINES)
   ) u_pos (
      .CLK        (CLK),
      .RESET      (RESET),
      .clear      (new_im),
      .step       (emit),
      .at_line_end(at_line_end),
      .last_line  (last_line)
   );

   // Next-state logic; new_im restarts the frame from any state.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      symbol_d    = symbol_q;
      abort_d     = 1'b0;
`ifdef RLE_SEQ_LINE_CHECK_EN
      err_d       = err_q;
`endif
      if (new_im) begin
         state_d     = StLoad;
         remaining_d = '0;
         symbol_d    = 1'b0;
         abort_d     = (state_q == StLoad) || (state_q == StExpand);
`ifdef RLE_SEQ_LINE_CHECK_EN
         err_d       = 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: state_d = StIdle;
            StLoad: begin
               if (xfer) begin
                  if (run_data == '0) begin
                     symbol_d = ~symbol_q;
                  end else begin
                     remaining_d = run_data;
                     state_d     = StExpand;
                  end
               end
            end
            StExpand: begin
               if (emit) begin
                  remaining_d = remaining_q - 1'b1;
                  if (at_line_end) begin
`ifdef RLE_SEQ_LINE_CHECK_EN
                     // Drop whatever of the run spills past the line.
                     if (!run_last) err_d = 1'b1;
                     remaining_d = '0;
                     symbol_d    = 1'b0;
                     state_d     = last_line ? StDone : StLoad;
`else
                     // A run still in flight spills into the next line unchanged.
                     if (last_line) begin
                        remaining_d = '0;
                        symbol_d    = 1'b0;
                        state_d     = StDone;
                     end else if (run_last) begin
                        symbol_d = 1'b0;
                        state_d  = StLoad;
                     end
`endif
                  end else if (run_last) begin
                     symbol_d = ~symbol_q;
                     state_d  = StLoad;
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         symbol_q    <= 1'b0;
         abort_q     <= 1'b0;
`ifdef RLE_SEQ_LINE_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         symbol_q    <= symbol_d;
         abort_q     <= abort_d;
`ifdef RLE_SEQ_LINE_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign run_ready   = (state_q == StLoad);
   assign pix_valid   = emit;
   assign pix_out     = emit & symbol_q;
   assign line_end    = emit & at_line_end;
   assign frame_end   = (state_q == StDone);
   assign frame_abort = abort_q;
`ifdef RLE_SEQ_LINE_CHECK_EN
   assign err_overflow = err_q;
`else
   assign err_overflow = 1'b0;
`endif

endmodule

// File: doc/rle_line_sequencer.md
RLE_LINE_SEQUENCER -- requirements
Module: rle_line_sequencer

Interface
REQ-001 The block SHALL have parameter LINE_W, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter LINES, default 480, meaning lines per frame.
REQ-003 The block SHALL have parameter RUN_W, default 10, meaning the run-length word width.
REQ-004 The block SHALL have a single clock port, CLK (input, 1 bit); all logic is rising-edge.
REQ-005 The block SHALL have RESET (input, 1 bit); reset is synchronous and active-high.
REQ-006 The block SHALL have new_im (input, 1 bit), a one-cycle frame-start strobe.
REQ-007 The block SHALL have run_data (input, RUN_W bits), a run length in pixels.
REQ-008 The block SHALL have run_valid (input, 1 bit) and run_ready (output, 1 bit), the run-word handshake; a word transfers when both are high.
REQ-009 The block SHALL have fifo_full (input, 1 bit), backpressure from the VGA pixel FIFO.
REQ-010 The block SHALL have pix_out (output, 1 bit), the pixel symbol, and pix_valid (output, 1 bit), the FIFO write enable.
REQ-011 The block SHALL have line_end and frame_end (outputs, 1 bit each), one-cycle strobes.
REQ-012 The block SHALL have frame_abort (output, 1 bit), a one-cycle strobe.
REQ-013 The block SHALL have err_overflow (output, 1 bit), a sticky error flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, EXPAND and DONE.
REQ-015 IDLE: run_ready=0 and pix_valid=0; new_im -> LOAD, with x=0, y=0 and symbol=0.
REQ-016 LOAD: run_ready=1; a transfer of a non-zero run latches remaining=run_data and goes to EXPAND.
REQ-017 LOAD: a transfer with run_data=0 SHALL toggle symbol and stay in LOAD, with no pixel emitted.
REQ-018 EXPAND: run_ready=0; each cycle with fifo_full=0 asserts pix_valid=1 and pix_out=symbol, decrements remaining and increments x.
REQ-019 EXPAND with fifo_full=1 SHALL hold all state and keep pix_valid=0; there is no pixel loss or duplication.
REQ-020 Latency: the first pixel of a run SHALL appear the cycle after the run transfers; throughput is one pixel per cycle inside a run, plus one LOAD cycle per run.
REQ-021 The last pixel of a run (remaining=1) SHALL toggle symbol and return the FSM to LOAD.
REQ-022 When the pixel at x=LINE_W-1 is emitted, the block SHALL pulse line_end, set x=0, increment y and force symbol=0 for the next line.
REQ-023 On line end with y=LINES-1, the next state SHALL be DONE instead of LOAD.
REQ-024 DONE SHALL pulse frame_end for one cycle and go to IDLE.
REQ-025 new_im in LOAD or EXPAND SHALL pulse frame_abort and restart the frame exactly as in REQ-015; new_im in DONE SHALL restart the frame without an abort.
REQ-026 new_im coincident with a run transfer SHALL take priority; the word is consumed and discarded.
REQ-027 x SHALL be $clog2(LINE_W) bits wide, y $clog2(LINES) bits wide and remaining RUN_W bits wide, all unsigned with no wrap beyond these limits.

Reset
REQ-028 RESET SHALL force IDLE, x=0, y=0, remaining=0, symbol=0, run_ready=0, pix_valid=0, pix_out=0, line_end=0, frame_end=0, frame_abort=0 and err_overflow=0.
REQ-029 RESET SHALL override new_im and every other input in the same cycle.

Configuration
REQ-030 With macro RLE_SEQ_LINE_CHECK_EN defined: a run extending past x=LINE_W-1 SHALL be truncated at the line end, the remainder dropped and err_overflow set; err_overflow clears only on RESET or new_im.
REQ-031 With RLE_SEQ_LINE_CHECK_EN undefined: an overlong run SHALL continue into the next line with symbol unchanged, and err_overflow SHALL be tied to 0.

Structure
REQ-032 Package rle_seq_pkg SHALL hold the FSM state enum and the LINE_W, LINES and RUN_W defaults.
REQ-033 The x/y position counter with its line_end/last-line detect SHALL be sub-module rle_pos_counter.

Verification
REQ-034 Reset, then new_im, then runs 100, 200, 340 -> 100 zeros, 200 ones, 340 zeros; line_end on pixel 640; y=1.
REQ-035 Runs 0, 640 -> 640 ones; symbol resets to 0 for line 1.
REQ-036 fifo_full held for 5 cycles mid-run of 50 -> exactly 50 pix_valid pulses, no gaps other than the stall.
REQ-037 Run 700 at x=0 with the macro defined -> 640 pixels, line_end, err_overflow=1; without the macro -> 60 pixels continue on line 1 at the same symbol.
REQ-038 LINES=2, LINE_W=8, runs 8, 8 -> frame_end one cycle after the 16th pixel, then IDLE.
REQ-039 new_im at pixel 300 of line 3 -> frame_abort pulse, then x=0, y=0, symbol=0 and LOAD.
